// File: rtl/mul_ctrl_if.sv
// Host/datapath-facing signals of the repeated-addition multiplier controller.
// The controller takes the slave view; the host plus counter/accumulator side takes the master view.
interface mul_ctrl_if #(
    parameter int W = 16
);
    logic         start;
    logic [W-1:0] cnt_dout;
    logic         lda;
    logic         ldb;
    logic         decb;
    logic         clrp;
    logic         ldp;
    logic         busy;
    logic         done;
    logic [W-1:0] iter;

    modport master (
        output start, cnt_dout,
        input  lda, ldb, decb, clrp, ldp, busy, done, iter
    );

    modport slave (
        input  start, cnt_dout,
        output lda, ldb, decb, clrp, ldp, busy, done, iter
    );
endinterface

// File: rtl/mul_ctrl.sv
// Controller FSM for the repeated-addition multiplier; strobes are Moore-decoded from state.
// With B = n, done rises 3+n edges after start is accepted (3 edges when n = 0).
module mul_ctrl #(
    parameter int W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_CHK  = 3'd3,
        S_ACC  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t       state;
    state_t       nxt;
    logic         done_q;
    logic [W-1:0] iter_q;
    logic         cnt_zero;
    logic         cnt_one;
    logic         lda_o;
    logic         ldb_o;
    logic         decb_o;
    logic         clrp_o;
    logic         ldp_o;
    logic         busy_o;

    assign cnt_zero = (bus.cnt_dout == '0);
    assign cnt_one  = (bus.cnt_dout == W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // In S_ACC the decrement issued this cycle takes the counter from 1 to 0,
    // so the exit test looks one step ahead; any other value keeps accumulating.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? S_LDA : IDLE;
            S_LDA:   nxt = S_LDB;
            S_LDB:   nxt = S_CHK;
            S_CHK:   nxt = cnt_zero ? S_DONE : S_ACC;
            S_ACC:   nxt = cnt_one ? S_DONE : S_ACC;
            S_DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        lda_o  = 1'b0;
        ldb_o  = 1'b0;
        decb_o = 1'b0;
        clrp_o = 1'b0;
        ldp_o  = 1'b0;
        busy_o = (state != IDLE);
        case (state)
            S_LDA: begin
                lda_o  = 1'b1;
                clrp_o = 1'b1;
            end
            S_LDB: ldb_o = 1'b1;
            S_ACC: begin
                ldp_o  = 1'b1;
                decb_o = 1'b1;
            end
            default: ;
        endcase
    end

    // done stays up in IDLE until the next accepted start; iter counts S_ACC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            iter_q <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                done_q <= 1'b0;
            end else if (nxt == S_DONE && state != S_DONE) begin
                done_q <= 1'b1;
            end
            if (state == S_LDA) begin
                iter_q <= '0;
            end else if (state == S_ACC) begin
                iter_q <= iter_q + W'(1);
            end
        end
    end

    assign bus.lda  = lda_o;
    assign bus.ldb  = ldb_o;
    assign bus.decb = decb_o;
    assign bus.clrp = clrp_o;
    assign bus.ldp  = ldp_o;
    assign bus.busy = busy_o;
    assign bus.done = done_q;
    assign bus.iter = iter_q;
endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: models counter, A register and accumulator, checks against A*B and timing rules.
`timescale 1ns/1ps
module tb_mul_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_ctrl_if #(.W(W)) ifc ();
    mul_ctrl #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    // Host/datapath model
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] data_bus;
    logic [W-1:0] cnt;
    logic [W-1:0] a_reg;
    logic [31:0]  acc;

    assign data_bus     = ifc.lda ? op_a : (ifc.ldb ? op_b : '0);
    assign ifc.cnt_dout = cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_reg <= '0;
            acc   <= '0;
        end else begin
            if (ifc.ldb)       cnt <= data_bus;
            else if (ifc.decb) cnt <= cnt - 16'd1;
            if (ifc.lda)       a_reg <= data_bus;
            if (ifc.clrp)      acc <= '0;
            else if (ifc.ldp)  acc <= acc + {16'd0, a_reg};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Per-operation observations (cycle k = interval after edge k-1; edge 0 accepts start)
    int           r_lda_first, r_clrp_first, r_ldb_first;
    int           r_ldp_first, r_ldp_last, r_ldp_cnt, r_decb_cnt;
    int           r_done_edge, r_done_rises;
    logic         r_done_c1, r_busy_done, r_busy_idle, r_done_idle;
    logic [W-1:0] r_iter;
    logic [31:0]  r_acc;
    bit           r_to;

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int poke, input bit hold);
        int  cyc;
        logic prev_done;
        op_a = a;
        op_b = b;
        r_lda_first = -1; r_clrp_first = -1; r_ldb_first = -1;
        r_ldp_first = -1; r_ldp_last = -1; r_ldp_cnt = 0; r_decb_cnt = 0;
        r_done_edge = -1; r_done_rises = 0; r_to = 0;
        r_busy_done = 1'b0; r_busy_idle = 1'b1; r_done_idle = 1'b0;
        @(negedge clk);
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) ifc.start = 1'b0;
        r_done_c1 = ifc.done;
        prev_done = 1'b0;
        cyc = 1;
        while (1) begin
            if (ifc.lda  === 1'b1 && r_lda_first  < 0) r_lda_first  = cyc;
            if (ifc.clrp === 1'b1 && r_clrp_first < 0) r_clrp_first = cyc;
            if (ifc.ldb  === 1'b1 && r_ldb_first  < 0) r_ldb_first  = cyc;
            if (ifc.ldp === 1'b1) begin
                r_ldp_cnt++;
                if (r_ldp_first < 0) r_ldp_first = cyc;
                r_ldp_last = cyc;
            end
            if (ifc.decb === 1'b1) r_decb_cnt++;
            if (ifc.done === 1'b1 && prev_done !== 1'b1) begin
                r_done_rises++;
                if (r_done_edge < 0) r_done_edge = cyc - 1;
            end
            if (r_done_edge >= 0 && cyc == r_done_edge + 1) r_busy_done = ifc.busy;
            if (r_done_edge >= 0 && cyc == r_done_edge + 2) begin
                r_busy_idle = ifc.busy;
                r_done_idle = ifc.done;
                r_iter      = ifc.iter;
                r_acc       = acc;
                break;
            end
            if (cyc > 70000) begin
                r_to = 1;
                break;
            end
            if (cyc == poke)     ifc.start = 1'b1;
            else if (!hold)      ifc.start = 1'b0;
            prev_done = ifc.done;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int i;
        rst_n = 1'b0;
        ifc.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if ({ifc.lda, ifc.ldb, ifc.decb, ifc.clrp, ifc.ldp, ifc.busy, ifc.done, ifc.iter} !== 23'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: got lda%b ldb%b decb%b clrp%b ldp%b busy%b done%b iter%0d, want all 0",
                         k, ifc.lda, ifc.ldb, ifc.decb, ifc.clrp, ifc.ldp, ifc.busy, ifc.done, ifc.iter);
            end
        end
        op_a = 16'd7;
        op_b = 16'd1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        n_tests++;
        if (ifc.lda !== 1'b1 || ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_accept: got lda=%b busy=%b want 1 1", ifc.lda, ifc.busy);
        end
        i = 0;
        while (ifc.busy !== 1'b0 && i < 50) begin
            @(posedge clk);
            #1;
            i++;
        end
        n_tests++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b1 || acc !== 32'd7) begin
            n_fail++;
            $display("FAIL reset_first_op: got busy=%b done=%b acc=%0d want 0 1 7", ifc.busy, ifc.done, acc);
        end
    endtask

    task automatic test_basic();
        run_op(16'd5, 16'd3, 0, 0);
        n_tests++;
        if (r_to) begin n_fail++; $display("FAIL basic_timeout: got timeout want completion"); end
        n_tests++;
        if (r_done_c1 !== 1'b0) begin n_fail++; $display("FAIL basic_done_cleared: got %b want 0", r_done_c1); end
        n_tests++;
        if (r_lda_first != 1 || r_clrp_first != 1 || r_ldb_first != 2) begin
            n_fail++;
            $display("FAIL basic_load_cycles: got lda@%0d clrp@%0d ldb@%0d want 1 1 2", r_lda_first, r_clrp_first, r_ldb_first);
        end
        n_tests++;
        if (r_ldp_first != 4 || r_ldp_last != 6 || r_ldp_cnt != 3 || r_decb_cnt != 3) begin
            n_fail++;
            $display("FAIL basic_acc_window: got ldp %0d..%0d n=%0d decb n=%0d want 4..6 n=3 decb 3",
                     r_ldp_first, r_ldp_last, r_ldp_cnt, r_decb_cnt);
        end
        n_tests++;
        if (r_done_edge != 6) begin n_fail++; $display("FAIL basic_done_edge: got %0d want 6", r_done_edge); end
        n_tests++;
        if (r_iter !== 16'd3 || r_acc !== 32'd15) begin
            n_fail++;
            $display("FAIL basic_result: got iter=%0d acc=%0d want 3 15", r_iter, r_acc);
        end
        n_tests++;
        if (r_busy_done !== 1'b1 || r_busy_idle !== 1'b0 || r_done_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_done: got busy@done=%b busy@idle=%b done@idle=%b want 1 0 1",
                     r_busy_done, r_busy_idle, r_done_idle);
        end
    endtask

    task automatic test_zero();
        run_op(16'd9, 16'd0, 0, 0);
        n_tests++;
        if (r_ldp_cnt != 0 || r_decb_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_no_acc: got ldp=%0d decb=%0d want 0 0", r_ldp_cnt, r_decb_cnt);
        end
        n_tests++;
        if (r_done_edge != 3) begin n_fail++; $display("FAIL zero_done_edge: got %0d want 3", r_done_edge); end
        n_tests++;
        if (r_iter !== 16'd0 || r_acc !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_result: got iter=%0d acc=%0d want 0 0", r_iter, r_acc);
        end
    endtask

    task automatic test_max();
        run_op(16'd1, 16'hFFFF, 0, 0);
        n_tests++;
        if (r_to || r_decb_cnt != 65535 || r_ldp_cnt != 65535) begin
            n_fail++;
            $display("FAIL max_decb_count: got decb=%0d ldp=%0d timeout=%0d want 65535 65535 0", r_decb_cnt, r_ldp_cnt, r_to);
        end
        n_tests++;
        if (r_iter !== 16'hFFFF || r_done_edge != 65538) begin
            n_fail++;
            $display("FAIL max_result: got iter=%0d done_edge=%0d want 65535 65538", r_iter, r_done_edge);
        end
    endtask

    task automatic test_busy_start();
        logic [W-1:0] a;
        a = 16'(($urandom % 1000) + 1);
        run_op(a, 16'd4, 5, 0);
        n_tests++;
        if (r_done_rises != 1 || r_done_edge != 7 || r_lda_first != 1) begin
            n_fail++;
            $display("FAIL busy_start_norestart: got rises=%0d done_edge=%0d want 1 7", r_done_rises, r_done_edge);
        end
        n_tests++;
        if (r_iter !== 16'd4 || r_ldp_cnt != 4 || r_acc !== 32'(a) * 32'd4) begin
            n_fail++;
            $display("FAIL busy_start_result: got iter=%0d ldp=%0d acc=%0d want 4 4 %0d", r_iter, r_ldp_cnt, r_acc, 32'(a) * 32'd4);
        end
        n_tests++;
        if (ifc.done !== 1'b1) begin n_fail++; $display("FAIL busy_start_sticky: got done=%b want 1", ifc.done); end
        run_op(16'd2, 16'd1, 0, 0);
        n_tests++;
        if (r_done_c1 !== 1'b0 || r_done_edge != 4) begin
            n_fail++;
            $display("FAIL busy_start_reclear: got done@c1=%b done_edge=%0d want 0 4", r_done_c1, r_done_edge);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int exp_edge;
        for (int k = 0; k < 8; k++) begin
            a = 16'($urandom);
            b = 16'($urandom_range(0, 20));
            exp_edge = (b == 0) ? 3 : 3 + int'(b);
            run_op(a, b, 0, 0);
            n_tests++;
            if (r_to || r_acc !== 32'(a) * 32'(b) || r_iter !== b || r_done_edge != exp_edge || r_ldp_cnt != int'(b)) begin
                n_fail++;
                $display("FAIL random_op%0d A=%0d B=%0d: got acc=%0d iter=%0d done_edge=%0d ldp=%0d want %0d %0d %0d %0d",
                         k, a, b, r_acc, r_iter, r_done_edge, r_ldp_cnt, 32'(a) * 32'(b), b, exp_edge, b);
            end
        end
    endtask

    task automatic test_back_to_back();
        int i;
        run_op(16'd3, 16'd2, 0, 1);
        n_tests++;
        if (r_busy_idle !== 1'b0 || r_done_idle !== 1'b1 || r_acc !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_first: got busy=%b done=%b acc=%0d want 0 1 6", r_busy_idle, r_done_idle, r_acc);
        end
        op_a = 16'd9;
        op_b = 16'd5;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        n_tests++;
        if (ifc.lda !== 1'b1 || ifc.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: got lda=%b done=%b want 1 0", ifc.lda, ifc.done);
        end
        i = 0;
        while (ifc.done !== 1'b1 && i < 50) begin
            @(posedge clk);
            #1;
            i++;
        end
        n_tests++;
        if (ifc.done !== 1'b1 || ifc.iter !== 16'd5 || acc !== 32'd45) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b iter=%0d acc=%0d want 1 5 45", ifc.done, ifc.iter, acc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int i;
        logic [W-1:0] a;
        a = 16'($urandom_range(1, 500));
        op_a = a;
        op_b = 16'd10;
        @(negedge clk);
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        i = 0;
        while (ifc.iter !== 16'd4 && i < 50) begin
            @(posedge clk);
            #1;
            i++;
        end
        n_tests++;
        if (ifc.iter !== 16'd4 || ifc.ldp !== 1'b1 || acc !== 32'(a) * 32'd4) begin
            n_fail++;
            $display("FAIL arst_midacc: got iter=%0d ldp=%b acc=%0d want 4 1 %0d", ifc.iter, ifc.ldp, acc, 32'(a) * 32'd4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ifc.lda, ifc.ldb, ifc.decb, ifc.clrp, ifc.ldp, ifc.busy, ifc.done, ifc.iter} !== 23'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: got decb%b ldp%b busy%b done%b iter%0d want all 0",
                     ifc.decb, ifc.ldp, ifc.busy, ifc.done, ifc.iter);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(a, 16'd2, 0, 0);
        n_tests++;
        if (r_iter !== 16'd2 || r_done_edge != 5 || r_acc !== 32'(a) * 32'd2) begin
            n_fail++;
            $display("FAIL arst_recover: got iter=%0d done_edge=%0d acc=%0d want 2 5 %0d", r_iter, r_done_edge, r_acc, 32'(a) * 32'd2);
        end
    endtask

    initial begin
        ifc.start = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_busy_start();
        test_random();
        test_back_to_back();
        test_async_reset();
        test_max();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
